// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared constants and state encoding for the byte-serial instruction fetcher.
package ifetch_pkg;
    localparam int INSTR_W = 32;
    localparam int BYTE_W = 8;
    localparam int BYTES_PER_INSTR = 4;
    localparam int CNT_W = $clog2(BYTES_PER_INSTR);
    localparam int PC_STEP = 4;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_FULL = 2'd2} state_t;
endpackage

// File: rtl/ifetch_byte_sequencer_if.sv
// ifetch_byte_sequencer_if: memory, redirect and decode-side handshake bundle of the fetcher.
interface ifetch_byte_sequencer_if #(parameter int ADDR_W = 8);
    import ifetch_pkg::*;
    logic mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic mem_ack;
    logic [BYTE_W-1:0] mem_rdata;
    logic redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic id_valid;
    logic id_ready;
    logic [INSTR_W-1:0] id_instr;
    logic [ADDR_W-1:0] id_pc;
    modport master (
        output mem_req, mem_addr, id_valid, id_instr, id_pc,
        input mem_ack, mem_rdata, redirect_valid, redirect_pc, id_ready
    );
    modport slave (
        input mem_req, mem_addr, id_valid, id_instr, id_pc,
        output mem_ack, mem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/ifetch_assembler.sv
// ifetch_assembler: collects acked bytes into a little-endian word and flags the last byte.
module ifetch_assembler
    import ifetch_pkg::*;
(
    input logic clk,
    input logic rst_n,
    input logic en,
    input logic clear,
    input logic [BYTE_W-1:0] rdata,
    output logic [CNT_W-1:0] byte_cnt,
    output logic [INSTR_W-1:0] asm_buf,
    output logic done
);
    assign done = en && byte_cnt == CNT_W'(BYTES_PER_INSTR - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            asm_buf <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
            asm_buf <= '0;
        end else if (en) begin
            asm_buf[byte_cnt * BYTE_W +: BYTE_W] <= rdata;
            byte_cnt <= byte_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ifetch_byte_sequencer.sv
// ifetch_byte_sequencer: owns the PC, fetches 32-bit instructions a byte at a time and
// hands them to decode with one spare buffered instruction to ride out decode stalls.
module ifetch_byte_sequencer
    import ifetch_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic clk,
    input logic rst_n,
    ifetch_byte_sequencer_if.master bus
);
    state_t state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, asm_pc_q, asm_pc_d, id_pc_q, id_pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d, asm_buf;
    logic valid_q, valid_d, done, slot_free, fetch;
    logic [CNT_W-1:0] byte_cnt;

    assign fetch = state_q == S_FETCH;
    assign slot_free = !valid_q || bus.id_ready;
    assign bus.mem_req = fetch;
    assign bus.mem_addr = fetch ? {pc_q[ADDR_W-1:2], byte_cnt} : '0;
    assign bus.id_valid = valid_q;
    assign bus.id_instr = instr_q;
    assign bus.id_pc = id_pc_q;

    // A redirect in the same cycle as an ack must not land that stale byte.
    ifetch_assembler u_asm (
        .clk(clk),
        .rst_n(rst_n),
        .en(fetch && bus.mem_ack && !bus.redirect_valid),
        .clear(bus.redirect_valid),
        .rdata(bus.mem_rdata),
        .byte_cnt(byte_cnt),
        .asm_buf(asm_buf),
        .done(done)
    );

    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        asm_pc_d = asm_pc_q;
        valid_d = valid_q && !bus.id_ready;
        instr_d = instr_q;
        id_pc_d = id_pc_q;
        if (bus.redirect_valid) begin
            state_d = S_FETCH;
            pc_d = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
            valid_d = 1'b0;
        end else if (state_q == S_IDLE) begin
            state_d = S_FETCH;
        end else if (fetch && done) begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
            if (slot_free) begin
                instr_d = {bus.mem_rdata, asm_buf[INSTR_W-BYTE_W-1:0]};
                id_pc_d = pc_q;
                valid_d = 1'b1;
            end else begin
                state_d = S_FULL;
                asm_pc_d = pc_q;
            end
        end else if (state_q == S_FULL && bus.id_ready) begin
            state_d = S_FETCH;
            instr_d = asm_buf;
            id_pc_d = asm_pc_q;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q <= {RESET_PC[ADDR_W-1:2], 2'b00};
            asm_pc_q <= '0;
            valid_q <= 1'b0;
            instr_q <= '0;
            id_pc_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            asm_pc_q <= asm_pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            id_pc_q <= id_pc_d;
        end
    end
endmodule

// File: tb/tb_ifetch_byte_sequencer.sv
// tb_ifetch_byte_sequencer: directed scenarios against a byte memory holding mem[a]=a
// except addresses 0..3, which hold the instruction 32'h00100513.
module tb_ifetch_byte_sequencer;
    logic clk, rst_n, ack_en;
    logic [7:0] mem [256];
    int n_tests, n_fail;

    ifetch_byte_sequencer_if #(.ADDR_W(8)) bus ();

    ifetch_byte_sequencer #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.master)
    );

    assign bus.mem_ack = ack_en;
    assign bus.mem_rdata = mem[bus.mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ack_en = 1'b1;
        bus.id_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 8'h00;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus.mem_req, bus.mem_addr, bus.id_valid, bus.id_instr, bus.id_pc} !== 50'h0) begin
            n_fail++;
            $display("FAIL reset req=%b addr=%h v=%b instr=%h pc=%h exp all zero",
                     bus.mem_req, bus.mem_addr, bus.id_valid, bus.id_instr, bus.id_pc);
        end
    endtask

    task automatic test_first_fetch();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if ({bus.mem_req, bus.mem_addr, bus.id_valid} !== {1'b1, 8'(i), 1'b0}) begin
                n_fail++;
                $display("FAIL first_addr%0d req=%b addr=%h v=%b exp 1 %h 0", i,
                         bus.mem_req, bus.mem_addr, bus.id_valid, 8'(i));
            end
        end
        step();
        n_tests++;
        if ({bus.id_valid, bus.id_instr, bus.id_pc, bus.mem_addr} !== {1'b1, 32'h00100513, 8'h00, 8'h04}) begin
            n_fail++;
            $display("FAIL first_instr v=%b instr=%h pc=%h addr=%h exp 1 00100513 00 04",
                     bus.id_valid, bus.id_instr, bus.id_pc, bus.mem_addr);
        end
    endtask

    task automatic test_stall();
        bus.id_ready = 1'b0;
        repeat (12) step();
        n_tests++;
        if ({bus.mem_req, bus.id_valid, bus.id_instr, bus.id_pc} !== {1'b0, 1'b1, 32'h00100513, 8'h00}) begin
            n_fail++;
            $display("FAIL stall_full req=%b v=%b instr=%h pc=%h exp 0 1 00100513 00",
                     bus.mem_req, bus.id_valid, bus.id_instr, bus.id_pc);
        end
        bus.id_ready = 1'b1;
        step();
        n_tests++;
        if ({bus.id_valid, bus.id_instr, bus.id_pc, bus.mem_req, bus.mem_addr} !== {1'b1, 32'h07060504, 8'h04, 1'b1, 8'h08}) begin
            n_fail++;
            $display("FAIL stall_release v=%b instr=%h pc=%h req=%b addr=%h exp 1 07060504 04 1 08",
                     bus.id_valid, bus.id_instr, bus.id_pc, bus.mem_req, bus.mem_addr);
        end
    endtask

    task automatic test_wait_states();
        repeat (2) step();
        ack_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if ({bus.mem_req, bus.mem_addr, bus.id_valid} !== {1'b1, 8'h0A, 1'b0}) begin
                n_fail++;
                $display("FAIL wait_hold%0d req=%b addr=%h v=%b exp 1 0a 0", i,
                         bus.mem_req, bus.mem_addr, bus.id_valid);
            end
        end
        ack_en = 1'b1;
        step();
        n_tests++;
        if ({bus.mem_addr, bus.id_valid} !== {8'h0B, 1'b0}) begin
            n_fail++;
            $display("FAIL wait_resume addr=%h v=%b exp 0b 0", bus.mem_addr, bus.id_valid);
        end
        step();
        n_tests++;
        if ({bus.id_valid, bus.id_instr, bus.id_pc, bus.mem_addr} !== {1'b1, 32'h0B0A0908, 8'h08, 8'h0C}) begin
            n_fail++;
            $display("FAIL wait_instr v=%b instr=%h pc=%h addr=%h exp 1 0b0a0908 08 0c",
                     bus.id_valid, bus.id_instr, bus.id_pc, bus.mem_addr);
        end
    endtask

    task automatic test_redirect();
        bus.id_ready = 1'b0;
        repeat (2) step();
        n_tests++;
        if ({bus.mem_addr, bus.id_valid, bus.id_instr} !== {8'h0E, 1'b1, 32'h0B0A0908}) begin
            n_fail++;
            $display("FAIL redir_pre addr=%h v=%b instr=%h exp 0e 1 0b0a0908",
                     bus.mem_addr, bus.id_valid, bus.id_instr);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 8'h43;
        step();
        bus.redirect_valid = 1'b0;
        bus.id_ready = 1'b1;
        n_tests++;
        if ({bus.mem_req, bus.mem_addr, bus.id_valid} !== {1'b1, 8'h40, 1'b0}) begin
            n_fail++;
            $display("FAIL redir_flush req=%b addr=%h v=%b exp 1 40 0",
                     bus.mem_req, bus.mem_addr, bus.id_valid);
        end
        repeat (3) step();
        n_tests++;
        if ({bus.mem_addr, bus.id_valid} !== {8'h43, 1'b0}) begin
            n_fail++;
            $display("FAIL redir_mid addr=%h v=%b exp 43 0", bus.mem_addr, bus.id_valid);
        end
        step();
        n_tests++;
        if ({bus.id_valid, bus.id_instr, bus.id_pc, bus.mem_addr} !== {1'b1, 32'h43424140, 8'h40, 8'h44}) begin
            n_fail++;
            $display("FAIL redir_instr v=%b instr=%h pc=%h addr=%h exp 1 43424140 40 44",
                     bus.id_valid, bus.id_instr, bus.id_pc, bus.mem_addr);
        end
    endtask

    task automatic test_wrap();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 8'hFE;
        step();
        bus.redirect_valid = 1'b0;
        n_tests++;
        if (bus.mem_addr !== 8'hFC) begin
            n_fail++;
            $display("FAIL wrap_start addr=%h exp fc", bus.mem_addr);
        end
        repeat (4) step();
        n_tests++;
        if ({bus.id_valid, bus.id_instr, bus.id_pc, bus.mem_addr} !== {1'b1, 32'hFFFEFDFC, 8'hFC, 8'h00}) begin
            n_fail++;
            $display("FAIL wrap_instr v=%b instr=%h pc=%h addr=%h exp 1 fffefdfc fc 00",
                     bus.id_valid, bus.id_instr, bus.id_pc, bus.mem_addr);
        end
    endtask

    task automatic test_back_to_back();
        step();
        n_tests++;
        if ({bus.id_valid, bus.mem_addr} !== {1'b0, 8'h01}) begin
            n_fail++;
            $display("FAIL b2b_consume v=%b addr=%h exp 0 01", bus.id_valid, bus.mem_addr);
        end
        repeat (3) step();
        n_tests++;
        if ({bus.id_valid, bus.id_instr, bus.id_pc, bus.mem_addr} !== {1'b1, 32'h00100513, 8'h00, 8'h04}) begin
            n_fail++;
            $display("FAIL b2b_instr v=%b instr=%h pc=%h addr=%h exp 1 00100513 00 04",
                     bus.id_valid, bus.id_instr, bus.id_pc, bus.mem_addr);
        end
    endtask

    task automatic test_reset_mid();
        bus.id_ready = 1'b0;
        repeat (5) step();
        n_tests++;
        if ({bus.mem_req, bus.id_valid, bus.id_pc} !== {1'b0, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL rstmid_full req=%b v=%b pc=%h exp 0 1 00", bus.mem_req, bus.id_valid, bus.id_pc);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.mem_req, bus.mem_addr, bus.id_valid, bus.id_instr, bus.id_pc} !== 50'h0) begin
            n_fail++;
            $display("FAIL rstmid_async req=%b addr=%h v=%b instr=%h pc=%h exp all zero",
                     bus.mem_req, bus.mem_addr, bus.id_valid, bus.id_instr, bus.id_pc);
        end
        step();
        rst_n = 1'b1;
        bus.id_ready = 1'b1;
        step();
        n_tests++;
        if ({bus.mem_req, bus.mem_addr, bus.id_valid} !== {1'b1, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL rstmid_refetch req=%b addr=%h v=%b exp 1 00 0", bus.mem_req, bus.mem_addr, bus.id_valid);
        end
        repeat (4) step();
        n_tests++;
        if ({bus.id_valid, bus.id_instr, bus.id_pc} !== {1'b1, 32'h00100513, 8'h00}) begin
            n_fail++;
            $display("FAIL rstmid_instr v=%b instr=%h pc=%h exp 1 00100513 00",
                     bus.id_valid, bus.id_instr, bus.id_pc);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        for (int a = 0; a < 256; a++) mem[a] = 8'(a);
        mem[0] = 8'h13;
        mem[1] = 8'h05;
        mem[2] = 8'h10;
        mem[3] = 8'h00;
        test_reset();
        test_first_fetch();
        test_stall();
        test_wait_states();
        test_redirect();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ifetch_byte_sequencer.md
Name: ifetch_byte_sequencer

Overview:
- Fetch controller for the 8-bit pipeline.
- Reads each 32-bit instruction as four byte transfers from byte-wide instruction memory and assembles it little-endian.
- Presents the instruction and its PC to the decode stage (immediate generator, control decode) over a valid/ready handshake.
- Owns the PC, redirects it on branches and flushes stale work. One assembled instruction is buffered so fetch overlaps a decode stall.

Parameters:
- ADDR_W, 8: PC and memory address width.
- RESET_PC, 8'h00: first fetch address after reset. Bits [1:0] are ignored.

Ports:
- clk  in  1: single clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- mem_req  out  1: byte read request.
- mem_addr  out  ADDR_W: byte address. Valid while mem_req=1.
- mem_ack  in  1: same-cycle completion. mem_rdata is valid when mem_req & mem_ack.
- mem_rdata  in  8: returned byte.
- redirect_valid  in  1: branch/jump taken, flush fetch.
- redirect_pc  in  ADDR_W: new PC. Bits [1:0] are forced to 0.
- id_valid  out  1: id_instr/id_pc hold a valid instruction.
- id_ready  in  1: decode accepts this cycle.
- id_instr  out  32: assembled instruction. Byte 0 is in [7:0].
- id_pc  out  ADDR_W: address of id_instr.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values (take effect immediately on rst_n=0): state=IDLE, pc=RESET_PC&~3, byte_cnt=0, asm_buf=0, mem_req=0, mem_addr=0, id_valid=0, id_instr=0, id_pc=0.
- States:
  - IDLE: entered only by reset. Moves to FETCH on the first clock edge with rst_n=1.
  - FETCH: mem_req=1 and mem_addr={pc[ADDR_W-1:2], byte_cnt}, combinational from registers.
  - FULL: the assembled instruction is parked in asm_buf and mem_req=0.
- Memory transfers: no outstanding transactions; memory responds in the same cycle or holds mem_ack low (wait states). Each cycle with mem_req&mem_ack writes mem_rdata into asm_buf byte lane byte_cnt, then byte_cnt+1. The address stays stable until ack, except on redirect.
- Completion (the fourth ack, byte_cnt==3):
  - Output slot free (id_valid==0, or id_ready==1 this cycle): id_instr<={mem_rdata, asm_buf[23:0]}, id_pc<=pc, id_valid<=1. Stay in FETCH with byte_cnt=0 and pc<=pc+4.
  - Slot occupied and not accepted: move to FULL with asm_buf complete, asm_pc<=pc, pc<=pc+4.
- FULL: when id_ready=1, load id_instr/id_pc from asm_buf/asm_pc, keep id_valid=1, return to FETCH.
- Output handshake: id_valid&id_ready with no new load gives id_valid<=0. id_instr/id_pc are held stable while id_valid&!id_ready.
- Redirect: redirect_valid has top priority in any state (including IDLE post-reset edge, FULL, mid-instruction).
  - Next edge: pc<=redirect_pc&~3, byte_cnt<=0, id_valid<=0, asm_buf content discarded, state<=FETCH.
  - An ack in the same cycle is dropped.
  - A same-cycle id_valid&id_ready counts as consumed, but no new load occurs.
- PC arithmetic: pc+4 wraps modulo 2^ADDR_W (8'hFC -> 8'h00). byte_cnt wraps 3->0. mem_addr never carries into pc.
- Latency and throughput: with zero-wait memory, the first id_valid rises 5 edges after reset release (1 IDLE + 4 bytes). Sustained throughput is 1 instruction per 4 cycles when decode is always ready.
- Reset mid-operation: all state is lost immediately; the partial instruction is not delivered.

Decomposition:
- Shared package ifetch_pkg holds:
  - state localparams S_IDLE=2'd0, S_FETCH=2'd1, S_FULL=2'd2
  - INSTR_W=32, BYTE_W=8, BYTES_PER_INSTR=4
  - PC_STEP=4
- One natural sub-module: ifetch_assembler. It contains byte_cnt, the lane write of asm_buf, and the done pulse on the fourth byte. The FSM, pc and output register stay in the parent.

Test Plan:
- Reset release, memory returns 8'h13,8'h05,8'h10,8'h00 at addresses 0..3 with constant ack, id_ready=1 -> mem_addr 0,1,2,3 on cycles 1-4; id_valid on cycle 5 with id_instr=32'h00100513, id_pc=0; next fetch starts at addr 4.
- id_ready=0 for 12 cycles after first instruction -> second instruction fetched (addr 4-7), state FULL, mem_req=0, id_instr stable at 32'h00100513; id_ready=1 -> next cycle id_pc=4, fetch resumes at addr 8.
- mem_ack low 3 cycles on byte 2 -> mem_addr held at 2, no byte_cnt advance; instruction correct; id_valid delayed 3 cycles.
- redirect_valid=1, redirect_pc=8'h43 while byte_cnt=2 and ack=1 -> ack dropped; next mem_addr=8'h40; id_valid=0; instruction delivered with id_pc=8'h40.
- pc=8'hFC fetch completes -> id_pc=8'hFC, next mem_addr=8'h00.
- rst_n low mid-FULL with id_valid=1 -> id_valid, mem_req and id_instr are 0 before the next clock edge; after release, refetch from RESET_PC.
